// File: rtl/mul_handshake_responder.sv
// rtl/mul_handshake_responder.sv - shift-add multiplier behind a four-phase start/done handshake
module mul_handshake_responder #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic               busy,
    output logic [2*WIDTH-1:0] product,
    output logic               zf,
    output logic               nf
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic [PW-1:0]   product_q, product_d;
    logic            zf_q, zf_d;
    logic            nf_q, nf_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [PW-1:0]    addend, acc_sum, final_p;

    always_comb begin
        // Signed mode multiplies magnitudes; -2^(WIDTH-1) maps onto itself as an unsigned value.
        a_mag = a;
        b_mag = b;
        if (SIGNED && a[WIDTH-1]) a_mag = ~a + WIDTH'(1);
        if (SIGNED && b[WIDTH-1]) b_mag = ~b + WIDTH'(1);

        addend  = mplier_q[0] ? mcand_q : '0;
        acc_sum = acc_q + addend;
        final_p = neg_q ? (~acc_sum + PW'(1)) : acc_sum;

        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        zf_d      = zf_q;
        nf_d      = nf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH - 1);
                    neg_d    = SIGNED ? (a[WIDTH-1] ^ b[WIDTH-1]) : 1'b0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    product_d = final_p;
                    zf_d      = (final_p == '0);
                    nf_d      = final_p[PW-1];
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            zf_q      <= 1'b0;
            nf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            zf_q      <= zf_d;
            nf_q      <= nf_d;
        end
    end

    assign done    = (state_q == S_DONE);
    assign busy    = (state_q == S_CALC);
    assign product = product_q;
    assign zf      = zf_q;
    assign nf      = nf_q;
endmodule

// File: tb/tb_mul_handshake_responder.sv
// tb/tb_mul_handshake_responder.sv - self-checking bench for mul_handshake_responder
module tb_mul_handshake_responder;
    logic        clock = 1'b0;
    logic        reset, start, start4;
    logic [7:0]  a, b;
    logic [3:0]  a4, b4;
    logic        u8_done, u8_busy, u8_zf, u8_nf;
    logic [15:0] u8_product;
    logic        s8_done, s8_busy, s8_zf, s8_nf;
    logic [15:0] s8_product;
    logic        u4_done, u4_busy, u4_zf, u4_nf;
    logic [7:0]  u4_product;

    int n_cmp  = 0;
    int n_fail = 0;
    int lat, bcyc;
    bit ovl;

    mul_handshake_responder #(.WIDTH(8), .SIGNED(1'b0)) u8 (
        .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
        .done(u8_done), .busy(u8_busy), .product(u8_product), .zf(u8_zf), .nf(u8_nf));
    mul_handshake_responder #(.WIDTH(8), .SIGNED(1'b1)) s8 (
        .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
        .done(s8_done), .busy(s8_busy), .product(s8_product), .zf(s8_zf), .nf(s8_nf));
    mul_handshake_responder #(.WIDTH(4), .SIGNED(1'b0)) u4 (
        .clock(clock), .reset(reset), .start(start4), .a(a4), .b(b4),
        .done(u4_done), .busy(u4_busy), .product(u4_product), .zf(u4_zf), .nf(u4_nf));

    always #5 clock = ~clock;

    // Reference: plain integer multiply of the operands as w-bit (signed or unsigned) numbers.
    function automatic logic [15:0] ref_mul(input int w, input bit sg, input logic [7:0] x, input logic [7:0] y);
        longint xv, yv, p;
        xv = longint'(x) & ((longint'(1) << w) - 1);
        yv = longint'(y) & ((longint'(1) << w) - 1);
        if (sg && xv >= (longint'(1) << (w - 1))) xv = xv - (longint'(1) << w);
        if (sg && yv >= (longint'(1) << (w - 1))) yv = yv - (longint'(1) << w);
        p = xv * yv;
        return 16'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clock); a = av; b = bv; start = 1'b1;
        @(posedge clock); #1;
        lat = 0; bcyc = 0; ovl = 1'b0;
        if (u8_busy) bcyc++;
        while (!u8_done && lat < 40) begin
            @(posedge clock); #1; lat++;
            if (u8_busy) bcyc++;
            if (u8_busy && u8_done) ovl = 1'b1;
        end
    endtask

    task automatic run_op4(input logic [3:0] av, input logic [3:0] bv);
        @(negedge clock); a4 = av; b4 = bv; start4 = 1'b1;
        @(posedge clock); #1;
        lat = 0;
        while (!u4_done && lat < 40) begin
            @(posedge clock); #1; lat++;
        end
    endtask

    task automatic release_start();
        @(negedge clock); start = 1'b0; start4 = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start4 = 1'b0; a = '0; b = '0; a4 = '0; b4 = '0;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (u8_done !== 1'b0 || u8_busy !== 1'b0) begin n_fail++; $display("FAIL reset_u8_flags: done=%b busy=%b want 0 0", u8_done, u8_busy); end
        n_cmp++; if (u8_product !== 16'h0 || u8_zf !== 1'b0 || u8_nf !== 1'b0) begin n_fail++; $display("FAIL reset_u8_result: product=%h zf=%b nf=%b want 0", u8_product, u8_zf, u8_nf); end
        n_cmp++; if (s8_product !== 16'h0 || s8_done !== 1'b0 || s8_busy !== 1'b0) begin n_fail++; $display("FAIL reset_s8: product=%h done=%b busy=%b want 0", s8_product, s8_done, s8_busy); end
        n_cmp++; if (u4_product !== 8'h0 || u4_done !== 1'b0 || u4_busy !== 1'b0) begin n_fail++; $display("FAIL reset_u4: product=%h done=%b busy=%b want 0", u4_product, u4_done, u4_busy); end
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_unsigned_basic();
        run_op8(8'h0F, 8'h0D);
        n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d edges want 8", lat); end
        n_cmp++; if (bcyc !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 8", bcyc); end
        n_cmp++; if (ovl !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done_overlap: got %b want 0", ovl); end
        n_cmp++; if (u8_product !== 16'h00C3 || u8_zf !== 1'b0 || u8_nf !== 1'b0) begin n_fail++; $display("FAIL basic_product: got %h zf=%b nf=%b want 00c3 0 0", u8_product, u8_zf, u8_nf); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            n_cmp++; if (u8_done !== 1'b1 || u8_product !== 16'h00C3) begin n_fail++; $display("FAIL basic_hold_%0d: done=%b product=%h want 1 00c3", i, u8_done, u8_product); end
        end
        release_start();
    endtask

    task automatic test_unsigned_edges();
        run_op8(8'hFF, 8'hFF);
        n_cmp++; if (u8_product !== 16'hFE01 || u8_nf !== 1'b1 || u8_zf !== 1'b0) begin n_fail++; $display("FAIL ff_ff_unsigned: got %h nf=%b zf=%b want fe01 1 0", u8_product, u8_nf, u8_zf); end
        n_cmp++; if (s8_product !== 16'h0001) begin n_fail++; $display("FAIL ff_ff_signed: got %h want 0001", s8_product); end
        release_start();
        run_op8(8'h00, 8'h5A);
        n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL zero_latency: got %0d edges want 8", lat); end
        n_cmp++; if (u8_product !== 16'h0000 || u8_zf !== 1'b1 || u8_nf !== 1'b0) begin n_fail++; $display("FAIL zero_product: got %h zf=%b nf=%b want 0000 1 0", u8_product, u8_zf, u8_nf); end
        release_start();
    endtask

    task automatic test_signed();
        run_op8(8'hFD, 8'h05);
        n_cmp++; if (s8_product !== 16'hFFF1 || s8_nf !== 1'b1 || s8_zf !== 1'b0) begin n_fail++; $display("FAIL signed_m3x5: got %h nf=%b zf=%b want fff1 1 0", s8_product, s8_nf, s8_zf); end
        release_start();
        run_op8(8'h80, 8'h80);
        n_cmp++; if (s8_product !== 16'h4000 || s8_nf !== 1'b0) begin n_fail++; $display("FAIL signed_min_x_min: got %h nf=%b want 4000 0", s8_product, s8_nf); end
        n_cmp++; if (u8_product !== 16'h4000) begin n_fail++; $display("FAIL unsigned_80x80: got %h want 4000", u8_product); end
        release_start();
        run_op8(8'h80, 8'h01);
        n_cmp++; if (s8_product !== 16'hFF80 || s8_nf !== 1'b1) begin n_fail++; $display("FAIL signed_min_x1: got %h nf=%b want ff80 1", s8_product, s8_nf); end
        release_start();
    endtask

    task automatic test_handshake();
        logic [15:0] e;
        run_op8(8'h12, 8'h34);
        release_start();
        e = ref_mul(8, 1'b0, 8'h12, 8'h34);
        n_cmp++; if (u8_done !== 1'b0 || u8_busy !== 1'b0) begin n_fail++; $display("FAIL hs_idle_after_drop: done=%b busy=%b want 0 0", u8_done, u8_busy); end
        n_cmp++; if (u8_product !== e) begin n_fail++; $display("FAIL hs_product_held: got %h want %h", u8_product, e); end
        @(posedge clock); #1;
        n_cmp++; if (u8_busy !== 1'b0 || u8_product !== e) begin n_fail++; $display("FAIL hs_idle_stays: busy=%b product=%h want 0 %h", u8_busy, u8_product, e); end
        // Operands and start are scrambled during CALC; the result must use the accept-edge operands.
        @(negedge clock); a = 8'hA5; b = 8'h3C; start = 1'b1;
        @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock); a = 8'($urandom); b = 8'($urandom); start = 1'($urandom);
        end
        start = 1'b1;
        @(posedge clock); #1;
        n_cmp++; if (u8_done !== 1'b1) begin n_fail++; $display("FAIL hs_toggle_done: got %b want 1", u8_done); end
        n_cmp++; if (u8_product !== ref_mul(8, 1'b0, 8'hA5, 8'h3C)) begin n_fail++; $display("FAIL hs_toggle_unsigned: got %h want %h", u8_product, ref_mul(8, 1'b0, 8'hA5, 8'h3C)); end
        n_cmp++; if (s8_product !== ref_mul(8, 1'b1, 8'hA5, 8'h3C)) begin n_fail++; $display("FAIL hs_toggle_signed: got %h want %h", s8_product, ref_mul(8, 1'b1, 8'hA5, 8'h3C)); end
        release_start();
    endtask

    task automatic test_reset_mid();
        @(negedge clock); a = 8'h37; b = 8'h29; start = 1'b1;
        @(posedge clock);
        repeat (3) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        n_cmp++; if (u8_busy !== 1'b0 || u8_done !== 1'b0 || u8_product !== 16'h0) begin n_fail++; $display("FAIL midreset_state: busy=%b done=%b product=%h want 0 0 0", u8_busy, u8_done, u8_product); end
        n_cmp++; if (s8_product !== 16'h0 || s8_zf !== 1'b0 || s8_nf !== 1'b0) begin n_fail++; $display("FAIL midreset_s8: product=%h zf=%b nf=%b want 0", s8_product, s8_zf, s8_nf); end
        @(posedge clock); #1;
        n_cmp++; if (u8_busy !== 1'b0 || u8_done !== 1'b0) begin n_fail++; $display("FAIL reset_beats_start: busy=%b done=%b want 0 0", u8_busy, u8_done); end
        @(negedge clock); reset = 1'b0; start = 1'b0;
        @(posedge clock);
        run_op8(8'h37, 8'h29);
        n_cmp++; if (lat !== 8 || u8_product !== ref_mul(8, 1'b0, 8'h37, 8'h29)) begin n_fail++; $display("FAIL midreset_fresh: lat=%0d product=%h want 8 %h", lat, u8_product, ref_mul(8, 1'b0, 8'h37, 8'h29)); end
        release_start();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  av, bv;
        logic [15:0] eu, es;
        for (int i = 0; i < 20; i++) begin
            av = 8'($urandom); bv = 8'($urandom);
            eu = ref_mul(8, 1'b0, av, bv);
            es = ref_mul(8, 1'b1, av, bv);
            run_op8(av, bv);
            n_cmp++; if (lat !== 8 || ovl !== 1'b0) begin n_fail++; $display("FAIL b2b8_timing_%0d: lat=%0d overlap=%b want 8 0", i, lat, ovl); end
            n_cmp++; if (u8_product !== eu || u8_zf !== (eu == 16'h0) || u8_nf !== eu[15]) begin n_fail++; $display("FAIL b2b8_unsigned_%0d: %h*%h got %h zf=%b nf=%b want %h", i, av, bv, u8_product, u8_zf, u8_nf, eu); end
            n_cmp++; if (s8_product !== es || s8_zf !== (es == 16'h0) || s8_nf !== es[15]) begin n_fail++; $display("FAIL b2b8_signed_%0d: %h*%h got %h zf=%b nf=%b want %h", i, av, bv, s8_product, s8_zf, s8_nf, es); end
            release_start();
        end
        for (int i = 0; i < 20; i++) begin
            av = 8'($urandom_range(0, 15)); bv = 8'($urandom_range(0, 15));
            eu = ref_mul(4, 1'b0, av, bv);
            run_op4(av[3:0], bv[3:0]);
            n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL b2b4_latency_%0d: got %0d want 4", i, lat); end
            n_cmp++; if (u4_product !== eu[7:0] || u4_zf !== (eu[7:0] == 8'h0) || u4_nf !== eu[7]) begin n_fail++; $display("FAIL b2b4_product_%0d: %h*%h got %h zf=%b nf=%b want %h", i, av[3:0], bv[3:0], u4_product, u4_zf, u4_nf, eu[7:0]); end
            release_start();
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_unsigned_edges();
        test_signed();
        test_handshake();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
